// File: rtl/imem_axi_fetch_bridge_pkg.sv
// Shared types and constants for the instruction-side AXI4-Lite fetch bridge.
package imem_axi_fetch_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_EXOKAY   = 2'b01;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [1:0]  RESP_DECERR   = 2'b11;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [2:0]  AR_PROT_INSTR = 3'b100;

  // EXOKAY is meaningless on AXI4-Lite, so anything but OKAY is a fault.
  function automatic logic resp_is_error(input logic [1:0] resp);
    case (resp)
      RESP_OKAY:                            return 1'b0;
      RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: return 1'b1;
      default:                              return 1'b1;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/imem_axi_fetch_bridge_if.sv
// Fetch-unit request/response handshake and AXI4-Lite read channels.
interface imem_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              req;
  logic              flush;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              error;

  modport master (output addr, req, flush, input data, ready, error);
  modport slave  (input addr, req, flush, output data, ready, error);
endinterface

interface axi_lite_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (output araddr, arprot, arvalid, rready,
                  input  arready, rdata, rresp, rvalid);
  modport slave  (input  araddr, arprot, arvalid, rready,
                  output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/imem_axi_fetch_bridge.sv
// Single-outstanding instruction fetch master: one AXI4-Lite read per request,
// one-cycle ready pulse back to the fetch unit, flush discards in-flight data.
module imem_axi_fetch_bridge
  import imem_axi_fetch_bridge_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_INSTR,
  parameter logic [2:0]        AR_PROT  = AR_PROT_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  imem_fetch_if.slave   imem,
  axi_lite_rd_if.master m_axi
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              error_q, error_d;
  logic              ready_q, ready_d;
  logic              rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      drop_q    <= 1'b0;
      data_q    <= NOP_WORD;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      drop_q    <= drop_d;
      data_q    <= data_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    drop_d    = drop_q;
    data_d    = data_q;
    error_d   = 1'b0;
    ready_d   = 1'b0;
    rsp_err   = resp_is_error(m_axi.rresp);
    case (state_q)
      ST_IDLE: begin
        if (imem.req) begin
          if (is_misaligned(imem.addr[1:0])) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            error_d = 1'b1;
            data_d  = NOP_WORD;
          end else begin
            state_d   = ST_AR;
            araddr_d  = imem.addr;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_AR: begin
        // The address phase is never withdrawn; a flush only marks the beat for discard.
        if (imem.flush) drop_d = 1'b1;
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (m_axi.rvalid) begin
          if (drop_q || imem.flush) begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            error_d = rsp_err;
            data_d  = rsp_err ? NOP_WORD : m_axi.rdata;
          end
        end else if (imem.flush) begin
          drop_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem.data     = data_q;
  assign imem.ready    = ready_q;
  assign imem.error    = error_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.arprot  = AR_PROT;
  assign m_axi.rready  = (state_q == ST_R);

endmodule

// File: tb/tb_imem_axi_fetch_bridge.sv
// Directed bench for imem_axi_fetch_bridge: latency, wait states, errors, flush, reset.
module tb_imem_axi_fetch_bridge;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  imem_fetch_if  #(.ADDR_W(32), .DATA_W(32)) imem ();
  axi_lite_rd_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  imem_axi_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .imem  (imem),
    .m_axi (axi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem.addr = '0; imem.req = 1'b0; imem.flush = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready",   32'(imem.ready),  32'd0);
    chk("rst_error",   32'(imem.error),  32'd0);
    chk("rst_data",    imem.data,        NOP);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_araddr",  axi.araddr,       32'd0);
    chk("rst_rready",  32'(axi.rready),  32'd0);

    // T1: zero-wait fetch of 0x10
    imem.addr = 32'h10; imem.req = 1'b1; axi.arready = 1'b1;
    tick();
    chk("t1_arvalid", 32'(axi.arvalid), 32'd1);
    chk("t1_araddr",  axi.araddr,       32'h10);
    chk("t1_arprot",  32'(axi.arprot),  32'd4);
    chk("t1_ready_c1", 32'(imem.ready), 32'd0);
    tick();
    chk("t1_arvalid_r", 32'(axi.arvalid), 32'd0);
    chk("t1_rready",    32'(axi.rready),  32'd1);
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h0050_0093; axi.rresp = 2'b00;
    tick();
    chk("t1_ready", 32'(imem.ready), 32'd1);
    chk("t1_data",  imem.data,       32'h0050_0093);
    chk("t1_error", 32'(imem.error), 32'd0);
    chk("t1_rready_resp", 32'(axi.rready), 32'd0);
    axi.rvalid = 1'b0; imem.req = 1'b0;
    tick();
    chk("t1_ready_off", 32'(imem.ready), 32'd0);
    chk("t1_data_hold", imem.data,       32'h0050_0093);

    // T3: SLVERR at 0x100 returns NOP with error
    imem.addr = 32'h100; imem.req = 1'b1; axi.arready = 1'b1;
    tick(); tick();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D; axi.rresp = 2'b10;
    tick();
    chk("t3_ready", 32'(imem.ready), 32'd1);
    chk("t3_error", 32'(imem.error), 32'd1);
    chk("t3_data",  imem.data,       NOP);
    axi.rvalid = 1'b0; axi.rresp = 2'b00; imem.req = 1'b0;
    tick();

    // T2: arready low for 5 cycles, rvalid 3 cycles late
    imem.addr = 32'h20; imem.req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_hold", 32'(axi.arvalid), 32'd1);
      chk("t2_araddr_hold",  axi.araddr,       32'h20);
      tick();
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_no_ready", 32'(imem.ready),  32'd0);
      chk("t2_no_2nd_ar", 32'(axi.arvalid), 32'd0);
      tick();
    end
    axi.rvalid = 1'b1; axi.rdata = 32'h1234_5678;
    tick();
    chk("t2_ready", 32'(imem.ready), 32'd1);
    chk("t2_data",  imem.data,       32'h1234_5678);
    axi.rvalid = 1'b0; imem.req = 1'b0;
    tick();
    chk("t2_single_pulse", 32'(imem.ready),  32'd0);
    chk("t2_arvalid_idle", 32'(axi.arvalid), 32'd0);

    // T4: misaligned 0x6 answered locally at c+1
    imem.addr = 32'h6; imem.req = 1'b1;
    tick();
    chk("t4_ready",   32'(imem.ready),  32'd1);
    chk("t4_error",   32'(imem.error),  32'd1);
    chk("t4_data",    imem.data,        NOP);
    chk("t4_arvalid", 32'(axi.arvalid), 32'd0);
    imem.req = 1'b0;
    tick();
    chk("t4_ready_off",   32'(imem.ready),  32'd0);
    chk("t4_arvalid_off", 32'(axi.arvalid), 32'd0);

    // T5: flush during R discards 0xDEADBEEF; next fetch 0x200 returns its own word
    imem.addr = 32'h40; imem.req = 1'b1; axi.arready = 1'b1;
    tick(); tick();
    axi.arready = 1'b0; imem.flush = 1'b1; imem.req = 1'b0;
    tick();
    imem.flush = 1'b0;
    chk("t5_rready_after_flush", 32'(axi.rready), 32'd1);
    axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF;
    tick();
    chk("t5_no_ready",  32'(imem.ready), 32'd0);
    chk("t5_data_kept", imem.data,       NOP);
    chk("t5_idle",      32'(axi.rready), 32'd0);
    axi.rvalid = 1'b0;
    tick();
    chk("t5_no_ready2", 32'(imem.ready), 32'd0);
    // flush in IDLE alongside a request must not block acceptance
    imem.addr = 32'h200; imem.req = 1'b1; imem.flush = 1'b1;
    tick();
    imem.flush = 1'b0;
    chk("t5_arvalid", 32'(axi.arvalid), 32'd1);
    chk("t5_araddr",  axi.araddr,       32'h200);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h00A0_0113;
    tick();
    chk("t5_ready", 32'(imem.ready), 32'd1);
    chk("t5_data",  imem.data,       32'h00A0_0113);
    chk("t5_error", 32'(imem.error), 32'd0);
    axi.rvalid = 1'b0; imem.req = 1'b0;
    tick();

    // T6: reset while in AR abandons the transaction
    imem.addr = 32'h300; imem.req = 1'b1;
    tick();
    chk("t6_arvalid_pre", 32'(axi.arvalid), 32'd1);
    rst = 1'b1; imem.req = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6_arvalid", 32'(axi.arvalid), 32'd0);
    chk("t6_ready",   32'(imem.ready),  32'd0);
    chk("t6_data",    imem.data,        NOP);
    chk("t6_araddr",  axi.araddr,       32'd0);
    tick();
    chk("t6_stay_idle", 32'(axi.arvalid), 32'd0);
    imem.addr = 32'h8; imem.req = 1'b1;
    tick();
    chk("t6_restart_arvalid", 32'(axi.arvalid), 32'd1);
    chk("t6_restart_araddr",  axi.araddr,       32'h8);
    imem.req = 1'b0; axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h0000_0073;
    tick();
    chk("t6_restart_ready", 32'(imem.ready), 32'd1);
    chk("t6_restart_data",  imem.data,       32'h0000_0073);
    axi.rvalid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
